// File: rtl/mips_pkg.sv
// mips_pkg: shared definitions for the single-cycle MIPS-subset core.
//   - opcode / funct encodings
//   - ALU operation enum
//   - control-signal struct produced by the main decoder
//   - sign-extension helper for 16-bit immediates
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;    // 1: second ALU operand is the sign-extended immediate
    logic reg_dst;    // 1: write rd, 0: write rt
    logic branch;
    logic jump;
  } ctrl_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 32 x 32-bit register file.
//   clk          rising-edge write clock
//   we           write enable (caller gates it with reset)
//   ra1, ra2     combinational read addresses
//   wa, wd       write address / data
//   rd1, rd2     read data; register 0 always reads as zero
// The array is deliberately not reset so that preloaded contents survive reset.
module mips_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);

  logic [31:0] registers [0:31];

  // Writes to $0 are dropped; reads of $0 are forced to zero below as well,
  // so the physical entry 0 never matters.
  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) begin
      registers[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : registers[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : registers[ra2];

endmodule

// File: rtl/mips_single_cycle_cpu.sv
// mips_single_cycle_cpu: single-cycle 32-bit MIPS-subset processor.
//   clk      rising-edge clock
//   reset    asynchronous active-low reset (0 = in reset)
//   pc_out   current program counter (byte address)
// Internal storage: IM.mem[] (instructions), RF.registers[] (register file),
// DM.location[] (data). None of them is cleared by reset.
// Supported: ADD SUB AND OR SLT LW SW BEQ ADDI; everything else is a NOP.
// Build option MIPS_JUMP_EN: when defined, J (op 0x02) is executed.
module mips_single_cycle_cpu
  import mips_pkg::*;
#(
  parameter int          IMEM_DEPTH = 256,
  parameter int          DMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_out
);

  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [5:0]  funct;
  logic [31:0] simm;
  ctrl_t       ctrl;
  alu_op_t     alu_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] alu_b;
  logic [31:0] alu_res;
  logic [31:0] dm_rdata;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic [31:0] branch_tgt;
  logic [31:0] jump_tgt;

  // ---------------- PC register ----------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= next_pc;
    end
  end

  assign pc_out   = pc;
  assign pc_plus4 = pc + 32'd4;

  // ---------------- instruction memory ----------------
  // Word-indexed by PC; the PC's low two bits and upper bits are dropped, so
  // fetch wraps modulo the memory depth.
  if (1) begin : IM
    logic [31:0] mem [0:IMEM_DEPTH-1];
    assign instr = mem[pc[IAW+1:2]];
  end

  // ---------------- decode ----------------
  assign op    = instr[31:26];
  assign rs    = instr[25:21];
  assign rt    = instr[20:16];
  assign rd    = instr[15:11];
  assign funct = instr[5:0];
  assign simm  = sign_ext16(instr[15:0]);

  always_comb begin
    ctrl   = '0;
    alu_op = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: ctrl.reg_write = 1'b0;  // unknown funct: NOP
        endcase
      end
      OP_LW: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.alu_src    = 1'b1;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        alu_op      = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_J: begin
`ifdef MIPS_JUMP_EN
        ctrl.jump = 1'b1;
`else
        ctrl.jump = 1'b0;  // jump disabled in this build: NOP
`endif
      end
      default: ;
    endcase
  end

  // ---------------- register file ----------------
  // Writes are suppressed while reset is low so that preloads stay intact.
  assign wb_addr = ctrl.reg_dst ? rd : rt;
  assign wb_data = ctrl.mem_to_reg ? dm_rdata : alu_res;

  mips_regfile RF (
    .clk (clk),
    .we  (reset && ctrl.reg_write),
    .ra1 (rs),
    .ra2 (rt),
    .wa  (wb_addr),
    .wd  (wb_data),
    .rd1 (rs_val),
    .rd2 (rt_val)
  );

  // ---------------- ALU ----------------
  assign alu_b = ctrl.alu_src ? simm : rt_val;

  always_comb begin
    case (alu_op)
      ALU_ADD: alu_res = rs_val + alu_b;
      ALU_SUB: alu_res = rs_val - alu_b;
      ALU_AND: alu_res = rs_val & alu_b;
      ALU_OR:  alu_res = rs_val | alu_b;
      ALU_SLT: alu_res = {31'd0, ($signed(rs_val) < $signed(alu_b))};
      default: alu_res = rs_val + alu_b;
    endcase
  end

  // ---------------- data memory ----------------
  // The ALU result is the byte address; its low two bits are ignored.
  // LW sees the value from before the edge because the read is combinational.
  if (1) begin : DM
    logic [31:0] location [0:DMEM_DEPTH-1];

    always_ff @(posedge clk) begin
      if (reset && ctrl.mem_write) begin
        location[alu_res[DAW+1:2]] <= rt_val;
      end
    end

    assign dm_rdata = ctrl.mem_read ? location[alu_res[DAW+1:2]] : 32'd0;
  end

  // ---------------- next PC ----------------
  assign branch_tgt = pc_plus4 + (simm << 2);
  assign jump_tgt   = {pc_plus4[31:28], instr[25:0], 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (ctrl.jump) begin
      next_pc = jump_tgt;
    end else if (ctrl.branch && (rs_val == rt_val)) begin
      next_pc = branch_tgt;
    end
  end

endmodule

// File: tb/tb_mips_single_cycle_cpu.sv
// tb_mips_single_cycle_cpu: directed program followed by random programs,
// checked against an instruction-level reference model of the ISA.
module tb_mips_single_cycle_cpu;

  localparam int DEPTH = 256;
  localparam logic [31:0] NOP_WORD = 32'hFC00_0000;  // opcode 0x3F, unknown

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_out;

  always #5 clk = ~clk;

  mips_single_cycle_cpu #(
    .IMEM_DEPTH (DEPTH),
    .DMEM_DEPTH (DEPTH),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .pc_out (pc_out)
  );

  // ---------------- reference model state ----------------
  logic [31:0] m_im [DEPTH];
  logic [31:0] m_rf [32];
  logic [31:0] m_dm [DEPTH];
  logic [31:0] m_pc;

  int checks = 0;
  int errors = 0;

  // ---------------- encoders ----------------
  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  a;
    logic [4:0]  b;
    logic [4:0]  c;
    logic [15:0] imm;
    int          off;
    a   = 5'($urandom_range(0, 7));
    b   = 5'($urandom_range(0, 7));
    c   = 5'($urandom_range(0, 7));
    imm = 16'($urandom);
    off = int'($urandom_range(0, 6)) - 2;
    case ($urandom_range(0, 11))
      0:  return enc_r(c, a, b, 6'h20);
      1:  return enc_r(c, a, b, 6'h22);
      2:  return enc_r(c, a, b, 6'h24);
      3:  return enc_r(c, a, b, 6'h25);
      4:  return enc_r(c, a, b, 6'h2A);
      5:  return enc_i(6'h23, a, b, imm);
      6:  return enc_i(6'h2B, a, b, imm);
      7:  return enc_i(6'h04, a, b, 16'(off));
      8:  return enc_i(6'h08, a, b, imm);
      9:  return {6'h02, 26'($urandom)};
      10: return enc_r(c, a, b, 6'h21);
      default: return {6'h3F, 26'($urandom)};
    endcase
  endfunction

  // ---------------- reference model ----------------
  task automatic wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_rf[r] = v;
  endtask

  task automatic model_step();
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] simm;
    logic [31:0] npc;
    logic [31:0] addr;
    ins  = m_im[(m_pc >> 2) % DEPTH];
    a    = m_rf[ins[25:21]];
    b    = m_rf[ins[20:16]];
    simm = {{16{ins[15]}}, ins[15:0]};
    npc  = m_pc + 32'd4;
    addr = a + simm;
    case (ins[31:26])
      6'h00: begin
        case (ins[5:0])
          6'h20: wr(ins[15:11], a + b);
          6'h22: wr(ins[15:11], a - b);
          6'h24: wr(ins[15:11], a & b);
          6'h25: wr(ins[15:11], a | b);
          6'h2A: wr(ins[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
          default: ;
        endcase
      end
      6'h23: wr(ins[20:16], m_dm[(addr >> 2) % DEPTH]);
      6'h2B: m_dm[(addr >> 2) % DEPTH] = b;
      6'h04: if (a == b) npc = npc + (simm << 2);
      6'h08: wr(ins[20:16], a + simm);
      6'h02: begin
`ifdef MIPS_JUMP_EN
        npc = {npc[31:28], ins[25:0], 2'b00};
`endif
      end
      default: ;
    endcase
    m_pc = npc;
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_rf();
    for (int i = 0; i < 32; i++) check($sformatf("rf[%0d]", i), dut.RF.registers[i], m_rf[i]);
  endtask

  task automatic check_dm();
    for (int i = 0; i < DEPTH; i++) check($sformatf("dm[%0d]", i), dut.DM.location[i], m_dm[i]);
  endtask

  task automatic preload_all();
    for (int i = 0; i < DEPTH; i++) begin
      dut.IM.mem[i]      = m_im[i];
      dut.DM.location[i] = m_dm[i];
    end
    for (int i = 0; i < 32; i++) dut.RF.registers[i] = m_rf[i];
  endtask

  // One clock of execution in DUT and model, then compare PC and registers.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("pc", pc_out, m_pc);
    check_rf();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1'b1;
    #1 reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      m_im[i] = NOP_WORD;
      m_dm[i] = 32'd0;
    end
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_rf[1] = 32'd10;
    m_rf[2] = 32'd20;
    m_rf[5] = 32'd50;
    m_rf[6] = 32'd10;
    m_rf[7] = 32'd5;
    m_dm[3] = 32'd77;
    m_dm[4] = 32'd100;
    m_im[0] = enc_r(5'd3, 5'd1, 5'd2, 6'h20);          // ADD  $3,$1,$2
    m_im[1] = enc_i(6'h23, 5'd1, 5'd4, 16'd4);          // LW   $4,4($1)
    m_im[2] = enc_i(6'h2B, 5'd1, 5'd5, 16'd8);          // SW   $5,8($1)
    m_im[3] = enc_i(6'h04, 5'd1, 5'd6, 16'd2);          // BEQ  $1,$6,2
    m_im[4] = enc_r(5'd8, 5'd1, 5'd7, 6'h22);          // SUB  $8,$1,$7
    m_im[6] = enc_i(6'h08, 5'd1, 5'd0, 16'd5);          // ADDI $0,$1,5
    preload_all();
    m_pc = 32'd0;

    #1 check("reset_pc", pc_out, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    step(); check("add_r3", dut.RF.registers[3], 32'd30); check("add_pc", pc_out, 32'd4);
    step(); check("lw_r4", dut.RF.registers[4], 32'd77);  check("lw_pc", pc_out, 32'd8);
    step(); check("sw_dm4", dut.DM.location[4], 32'd50);  check("sw_pc", pc_out, 32'd12);
    step(); check("beq_taken_pc", pc_out, 32'd24);
    step(); check("addi_r0", dut.RF.registers[0], 32'd0); check("addi_pc", pc_out, 32'd28);
    step(); check("nop_pc", pc_out, 32'd32); check("skipped_r8", dut.RF.registers[8], 32'd0);
    check_dm();

    // Asynchronous reset in the middle of a cycle.
    @(posedge clk);
    model_step();
    #3 reset = 1'b0;
    #1 check("async_reset_pc", pc_out, 32'd0);
    m_pc = 32'd0;
    check_rf();
    check_dm();

    // While held in reset no writes happen even though IM[0] is an ADD.
    m_rf[3] = 32'd99;
    m_rf[6] = 32'd11;
    dut.RF.registers[3] = 32'd99;
    dut.RF.registers[6] = 32'd11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("held_pc", pc_out, 32'd0);
    check("held_r3", dut.RF.registers[3], 32'd99);
    reset = 1'b1;

    step(); check("rerun_add_r3", dut.RF.registers[3], 32'd30);
    step();
    step();
    step(); check("beq_not_taken_pc", pc_out, 32'd16);
    step(); check("sub_r8", dut.RF.registers[8], 32'd5); check("sub_pc", pc_out, 32'd20);

    // Random programs and data.
    for (int run = 0; run < 3; run++) begin
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        m_im[i] = rand_instr();
        m_dm[i] = $urandom;
      end
      m_rf[0] = 32'd0;
      for (int i = 1; i < 32; i++) m_rf[i] = (i % 2 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      preload_all();
      m_pc = 32'd0;
      #1 check("rand_reset_pc", pc_out, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      for (int k = 0; k < 150; k++) step();
      check_dm();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
